ysyx_24090018_idu_stage: RTL and testbench
==========================================

// Module: ysyx_24090018_idu_stage
// PURPOSE
//  Registered RV32I decode stage between IFU and EXU. Decodes all base formats (R/I/S/B/U/J),
//  drives regfile read addresses, builds operands/immediate, and holds one decoded instruction
//  in an output pipeline register with valid/ready handshakes on both sides plus a flush input.
// PARAMETERS
//  DATA_WIDTH   32  datapath / instruction / PC width
//  ADDR_WIDTH   5   register-file address width
//  ALUOP_WIDTH  4   width of ALU operation code
// PORTS
//  clk            in   1            clock; all state updates on rising edge
//  rst            in   1            synchronous reset, active-high
//  in_valid_i     in   1            IFU presents inst_i/pc_i
//  in_ready_o     out  1            stage can accept this cycle
//  inst_i         in   DATA_WIDTH   instruction word
//  pc_i           in   DATA_WIDTH   instruction PC
//  flush_i        in   1            kill held and incoming instruction
//  rf_raddr1_o    out  ADDR_WIDTH   combinational rs1 address
//  rf_raddr2_o    out  ADDR_WIDTH   combinational rs2 address
//  rf_rdata1_i    in   DATA_WIDTH   rs1 data, same cycle
//  rf_rdata2_i    in   DATA_WIDTH   rs2 data, same cycle
//  out_valid_o    out  1            decoded bundle valid to EXU
//  out_ready_i    in   1            EXU accepts bundle
//  op1_o/op2_o    out  DATA_WIDTH   ALU operands
//  imm_o          out  DATA_WIDTH   sign-extended immediate (branch/jump/store offset)
//  rs2_data_o     out  DATA_WIDTH   store data / branch compare
//  rf_waddr_o     out  ADDR_WIDTH   destination register
//  rf_we_o        out  1            writeback enable
//  alu_op_o       out  ALUOP_WIDTH  0ADD 1SUB 2SLL 3SLT 4SLTU 5XOR 6SRL 7SRA 8OR 9AND 10PASS2
//  funct3_o       out  3            raw funct3 (load size, branch cond)
//  is_load_o/is_store_o/is_branch_o/is_jump_o  out 1  class flags
//  illegal_o      out  1            unknown opcode/funct (macro-dependent)
// BEHAVIOUR
//  - Reset: out_valid_o=0; every registered output 0. Reset overrides flush and capture.
//  - in_ready_o = !out_valid_o | out_ready_i (combinational, no dependency on in_valid_i).
//  - capture = in_valid_i & in_ready_o & !flush_i; bundle registered on capture, latency 1 cycle.
//  - out_valid_o next: 0 if flush_i; else 1 if capture; else 0 if out_ready_i; else hold.
//  - Stall (out_valid_o & !out_ready_i): all outputs stable, in_ready_o=0.
//  - Back-to-back: accept and hand off in same cycle, full throughput.
//  - Read addrs from inst_i every cycle: rs1 for R/I/S/B/JALR, rs2 for R/S/B, else 0.
//  - Imm: I {20{i31},i[31:20]}; S {i[31:25],i[11:7]}; B {i[7],i[30:25],i[11:8],0};
//    U {i[31:12],12'b0}; J {i[19:12],i[20],i[30:21],0}; all sign-extended from i[31].
//  - Operands: OP rs1,rs2; OP-IMM/LOAD/JALR rs1,imm (JALR op2=4, imm=offset); STORE rs1,imm;
//    BRANCH rs1,rs2 (alu SUB); LUI 0,imm PASS2; AUIPC pc,imm ADD; JAL pc,4 ADD.
//  - OP-IMM shifts: shamt=i[24:20]; i[30] selects SRA vs SRL; SUB only for OP with i[30].
//  - rf_we_o=1 for R/I/LOAD/U/JAL/JALR, 0 for S/B; forced 0 when rd==0; rf_waddr_o=0 when we=0.
//  - Unrecognised opcode: bundle = NOP (we=0, flags 0, alu ADD, operands 0).
// CONFIGURATION
//  YSYX_24090018_IDU_ILLEGAL_EN defined: illegal_o=1 for unknown opcode, or invalid funct7 on
//  OP / shift-imm; bundle still NOP. Undefined: illegal_o tied 0, same NOP decode.
// TESTING
//  1 rst=1 two cycles, in_valid_i=1 -> out_valid_o=0, all outputs 0, in_ready_o=1 after release.
//  2 addi x5,x1,-3 (0xFFD08293), x1=10 -> next cycle op1=10, op2=0xFFFFFFFD, waddr=5, we=1, ADD.
//  3 sw x2,8(x1) then out_ready_i=0 3 cycles -> we=0, is_store=1, imm=8, outputs held, in_ready_o=0.
//  4 jal x1,+0x800 at pc 0x80000000 -> op1=0x80000000, op2=4, imm=0x800, is_jump=1, we=1.
//  5 flush_i with in_valid_i=1 while out_valid_o=1 -> out_valid_o=0 next cycle, nothing captured.
//  6 inst 0x0000007F -> NOP bundle; illegal_o=1 only with YSYX_24090018_IDU_ILLEGAL_EN.

Source files
------------

// File: rtl/ysyx_24090018_idu_stage.sv
// rtl/ysyx_24090018_idu_stage.sv - registered RV32I decode stage between IFU and EXU
//
// Decodes one RV32I instruction per cycle into an ALU-ready bundle held in an
// output pipeline register. It uses valid/ready handshakes on both sides and a flush input.
//
// Configuration macro: YSYX_24090018_IDU_ILLEGAL_EN
//   When defined, illegal_o flags an unknown opcode or a bad funct7 on OP/shift-imm.
//   When undefined, illegal_o stays 0.
//   In both builds those instructions decode to a NOP bundle.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid_i/in_ready_o        IFU handshake; inst_i, pc_i carry the instruction
//   flush_i                      drops the held bundle and any incoming instruction
//   rf_raddr1_o/rf_raddr2_o      combinational register-file read addresses
//   rf_rdata1_i/rf_rdata2_i      same-cycle register-file read data
//   out_valid_o/out_ready_i      EXU handshake
//   op1_o, op2_o, imm_o          ALU operands and sign-extended immediate
//   rs2_data_o                   store data / branch compare operand
//   rf_waddr_o, rf_we_o          destination register and writeback enable
//   alu_op_o, funct3_o           ALU operation, raw funct3
//   is_load_o .. is_jump_o       class flags
//   illegal_o                    unknown encoding (macro-dependent)

module ysyx_24090018_idu_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ALUOP_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [DATA_WIDTH-1:0]  pc_i,
  input  logic                   flush_i,
  output logic [ADDR_WIDTH-1:0]  rf_raddr1_o,
  output logic [ADDR_WIDTH-1:0]  rf_raddr2_o,
  input  logic [DATA_WIDTH-1:0]  rf_rdata1_i,
  input  logic [DATA_WIDTH-1:0]  rf_rdata2_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  op1_o,
  output logic [DATA_WIDTH-1:0]  op2_o,
  output logic [DATA_WIDTH-1:0]  imm_o,
  output logic [DATA_WIDTH-1:0]  rs2_data_o,
  output logic [ADDR_WIDTH-1:0]  rf_waddr_o,
  output logic                   rf_we_o,
  output logic [ALUOP_WIDTH-1:0] alu_op_o,
  output logic [2:0]             funct3_o,
  output logic                   is_load_o,
  output logic                   is_store_o,
  output logic                   is_branch_o,
  output logic                   is_jump_o,
  output logic                   illegal_o
);

`ifdef YSYX_24090018_IDU_ILLEGAL_EN
  localparam logic ILLEGAL_EN = 1'b1;
`else
  localparam logic ILLEGAL_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_PASS2 = ALUOP_WIDTH'(10);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];

  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // funct3 -> ALU op; alt picks SUB/SRA where the encoding allows it
  function automatic logic [ALUOP_WIDTH-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_f3 = ALUOP_WIDTH'(2);
      3'd2:    alu_from_f3 = ALUOP_WIDTH'(3);
      3'd3:    alu_from_f3 = ALUOP_WIDTH'(4);
      3'd4:    alu_from_f3 = ALUOP_WIDTH'(5);
      3'd5:    alu_from_f3 = alt ? ALUOP_WIDTH'(7) : ALUOP_WIDTH'(6);
      3'd6:    alu_from_f3 = ALUOP_WIDTH'(8);
      default: alu_from_f3 = ALUOP_WIDTH'(9);
    endcase
  endfunction

  // Read addresses depend only on the opcode format, not on funct legality
  always_comb begin
    rf_raddr1_o = '0;
    rf_raddr2_o = '0;
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        rf_raddr1_o = inst_i[19:15];
        rf_raddr2_o = inst_i[24:20];
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: rf_raddr1_o = inst_i[19:15];
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0]  d_op1, d_op2, d_imm, d_rs2;
  logic [ALUOP_WIDTH-1:0] d_alu;
  logic [2:0]             d_f3;
  logic                   d_we, d_ld, d_st, d_br, d_jp, d_bad;
  logic                   op_f7_ok, sh_f7_ok, is_shift;

  assign op_f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
  assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);
  assign sh_f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && funct3 == 3'd5);

  // Defaults form the NOP bundle; bad encodings simply never leave it
  always_comb begin
    d_op1 = '0;  d_op2 = '0;  d_imm = '0;  d_rs2 = '0;
    d_alu = ALU_ADD;  d_f3 = 3'd0;  d_we = 1'b0;
    d_ld = 1'b0;  d_st = 1'b0;  d_br = 1'b0;  d_jp = 1'b0;  d_bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (op_f7_ok) begin
          d_op1 = rf_rdata1_i;  d_op2 = rf_rdata2_i;  d_rs2 = rf_rdata2_i;
          d_alu = alu_from_f3(funct3, inst_i[30]);  d_f3 = funct3;  d_we = 1'b1;
        end else d_bad = 1'b1;
      end
      OPC_OP_IMM: begin
        if (!is_shift || sh_f7_ok) begin
          d_op1 = rf_rdata1_i;  d_imm = imm_i;  d_f3 = funct3;  d_we = 1'b1;
          // Shifts take the raw shamt; ADDI has no SUB variant
          d_op2 = is_shift ? {{(DATA_WIDTH-5){1'b0}}, inst_i[24:20]} : imm_i;
          d_alu = alu_from_f3(funct3, is_shift & inst_i[30]);
        end else d_bad = 1'b1;
      end
      OPC_LOAD: begin
        d_op1 = rf_rdata1_i;  d_op2 = imm_i;  d_imm = imm_i;
        d_f3 = funct3;  d_we = 1'b1;  d_ld = 1'b1;
      end
      OPC_JALR: begin
        // op2=4 yields the link value; imm carries the target offset
        d_op1 = rf_rdata1_i;  d_op2 = DATA_WIDTH'(4);  d_imm = imm_i;
        d_f3 = funct3;  d_we = 1'b1;  d_jp = 1'b1;
      end
      OPC_STORE: begin
        d_op1 = rf_rdata1_i;  d_op2 = imm_s;  d_imm = imm_s;  d_rs2 = rf_rdata2_i;
        d_f3 = funct3;  d_st = 1'b1;
      end
      OPC_BRANCH: begin
        d_op1 = rf_rdata1_i;  d_op2 = rf_rdata2_i;  d_imm = imm_b;  d_rs2 = rf_rdata2_i;
        d_alu = ALU_SUB;  d_f3 = funct3;  d_br = 1'b1;
      end
      OPC_LUI: begin
        d_op2 = imm_u;  d_imm = imm_u;  d_alu = ALU_PASS2;  d_we = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1 = pc_i;  d_op2 = imm_u;  d_imm = imm_u;  d_we = 1'b1;
      end
      OPC_JAL: begin
        d_op1 = pc_i;  d_op2 = DATA_WIDTH'(4);  d_imm = imm_j;  d_we = 1'b1;  d_jp = 1'b1;
      end
      default: d_bad = 1'b1;
    endcase
  end

  logic d_we_eff, capture;
  assign d_we_eff   = d_we && (rd != 5'd0);
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      op1_o       <= '0;
      op2_o       <= '0;
      imm_o       <= '0;
      rs2_data_o  <= '0;
      rf_waddr_o  <= '0;
      rf_we_o     <= 1'b0;
      alu_op_o    <= '0;
      funct3_o    <= 3'd0;
      is_load_o   <= 1'b0;
      is_store_o  <= 1'b0;
      is_branch_o <= 1'b0;
      is_jump_o   <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      if (flush_i)          out_valid_o <= 1'b0;
      else if (capture)     out_valid_o <= 1'b1;
      else if (out_ready_i) out_valid_o <= 1'b0;

      if (capture) begin
        op1_o       <= d_op1;
        op2_o       <= d_op2;
        imm_o       <= d_imm;
        rs2_data_o  <= d_rs2;
        rf_waddr_o  <= d_we_eff ? ADDR_WIDTH'(rd) : '0;
        rf_we_o     <= d_we_eff;
        alu_op_o    <= d_alu;
        funct3_o    <= d_f3;
        is_load_o   <= d_ld;
        is_store_o  <= d_st;
        is_branch_o <= d_br;
        is_jump_o   <= d_jp;
        illegal_o   <= d_bad & ILLEGAL_EN;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_idu_stage.sv
// tb/tb_ysyx_24090018_idu_stage.sv - self-checking bench for ysyx_24090018_idu_stage

module tb_ysyx_24090018_idu_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, rdata1, rdata2;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] op1, op2, imm, rs2_data;
  logic        we, is_load, is_store, is_branch, is_jump, illegal;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;

  always #5 clk = ~clk;

  ysyx_24090018_idu_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc), .flush_i(flush),
    .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2),
    .rf_rdata1_i(rdata1), .rf_rdata2_i(rdata2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op1_o(op1), .op2_o(op2), .imm_o(imm), .rs2_data_o(rs2_data),
    .rf_waddr_o(waddr), .rf_we_o(we), .alu_op_o(alu_op), .funct3_o(funct3),
    .is_load_o(is_load), .is_store_o(is_store), .is_branch_o(is_branch),
    .is_jump_o(is_jump), .illegal_o(illegal)
  );

  typedef struct {
    logic [31:0] op1, op2, imm, rs2;
    logic [4:0]  waddr;
    logic        we;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        ld, st, br, jp, ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

`ifdef YSYX_24090018_IDU_ILLEGAL_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  function automatic exp_t mk(logic [31:0] o1, logic [31:0] o2, logic [31:0] im, logic [31:0] r2,
                              logic [4:0] wa, logic w, logic [3:0] al, logic [2:0] f,
                              logic ld, logic st, logic br, logic jp, logic il);
    exp_t x;
    x.op1 = o1; x.op2 = o2; x.imm = im; x.rs2 = r2; x.waddr = wa; x.we = w;
    x.alu = al; x.f3 = f; x.ld = ld; x.st = st; x.br = br; x.jp = jp; x.ill = il;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input exp_t x);
    chk({tag, ".op1"},   op1,               x.op1);
    chk({tag, ".op2"},   op2,               x.op2);
    chk({tag, ".imm"},   imm,               x.imm);
    chk({tag, ".rs2"},   rs2_data,          x.rs2);
    chk({tag, ".waddr"}, 32'(waddr),        32'(x.waddr));
    chk({tag, ".we"},    32'(we),           32'(x.we));
    chk({tag, ".alu"},   32'(alu_op),       32'(x.alu));
    chk({tag, ".f3"},    32'(funct3),       32'(x.f3));
    chk({tag, ".flags"}, 32'({is_load, is_store, is_branch, is_jump}),
                         32'({x.ld, x.st, x.br, x.jp}));
    chk({tag, ".ill"},   32'(illegal),      32'(x.ill));
  endtask

  // One cycle: returns 1 time unit after the rising edge, where outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    inst = i; pc = p; rdata1 = r1; rdata2 = r2; in_valid = 1'b1;
  endtask

  // Pop the next expected bundle and compare it against what the DUT presents
  task automatic pop_check(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_bundle(tag, e);
    end
  endtask

  // Present one instruction with out_ready high, check read addresses, capture, check bundle
  task automatic send(input string tag, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [4:0] ra1, input logic [4:0] ra2, input exp_t x);
    drive(i, p, r1, r2);
    #1;
    chk({tag, ".raddr1"},   32'(raddr1),   32'(ra1));
    chk({tag, ".raddr2"},   32'(raddr2),   32'(ra2));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back(x);
    tick();
    in_valid = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(32'hFFD08293, 32'h0, 32'd10, 32'd0);

    // Reset wins over an asserted in_valid
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk_bundle("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // addi x5,x1,-3
    send("addi", 32'hFFD08293, 32'h80000000, 32'd10, 32'h1234, 5'd1, 5'd0,
         mk(32'd10, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 5'd5, 1, 4'd0, 3'd0, 0, 0, 0, 0, 0));

    // sw x2,8(x1) accepted back-to-back while addi is handed off
    drive(32'h0020A423, 32'h80000004, 32'h100, 32'hDEADBEEF);
    #1;
    chk("sw.raddr1",   32'(raddr1),   32'd1);
    chk("sw.raddr2",   32'(raddr2),   32'd2);
    chk("sw.in_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h100, 32'd8, 32'd8, 32'hDEADBEEF, 5'd0, 0, 4'd0, 3'd2, 0, 1, 0, 0, 0));
    tick();

    // Stall three cycles with lw x3,4(x2) waiting; sw bundle must not move
    out_ready = 1'b0;
    drive(32'h00412183, 32'h80000008, 32'h200, 32'h55);
    #1;
    chk("lw.raddr1", 32'(raddr1), 32'd2);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk("stall.valid",    32'(out_valid), 32'd1);
      chk("stall.in_ready", 32'(in_ready),  32'd0);
      chk_bundle("stall.sw", e);
      tick();
    end
    chk("stall.valid_end", 32'(out_valid), 32'd1);
    chk_bundle("stall.sw_end", e);
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h200, 32'd4, 32'd4, 0, 5'd3, 1, 4'd0, 3'd2, 1, 0, 0, 0, 0));
    tick();
    in_valid = 1'b0;
    pop_check("lw");

    // jal x1,+0x800
    send("jal", 32'h001000EF, 32'h80000000, 32'h77, 32'h88, 5'd0, 5'd0,
         mk(32'h80000000, 32'd4, 32'h800, 0, 5'd1, 1, 4'd0, 3'd0, 0, 0, 0, 1, 0));

    // Flush with a valid incoming instruction while jal is held
    chk("flush.pre_valid", 32'(out_valid), 32'd1);
    drive(32'h402083B3, 32'h0, 32'd1, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.valid",    32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready),  32'd1);
    tick();
    chk("flush.no_capture", 32'(out_valid), 32'd0);

    // sub x7,x1,x2
    send("sub", 32'h402083B3, 32'h0, 32'd50, 32'd8, 5'd1, 5'd2,
         mk(32'd50, 32'd8, 32'd0, 32'd8, 5'd7, 1, 4'd1, 3'd0, 0, 0, 0, 0, 0));
    // srai x6,x1,3
    send("srai", 32'h4030D313, 32'h0, 32'h80000000, 32'd9, 5'd1, 5'd0,
         mk(32'h80000000, 32'd3, 32'h403, 0, 5'd6, 1, 4'd7, 3'd5, 0, 0, 0, 0, 0));
    // beq x1,x2,-4
    send("beq", 32'hFE208EE3, 32'h0, 32'd5, 32'd5, 5'd1, 5'd2,
         mk(32'd5, 32'd5, 32'hFFFFFFFC, 32'd5, 5'd0, 0, 4'd1, 3'd0, 0, 0, 1, 0, 0));
    // lui x0,0x12345: rd==0 suppresses writeback
    send("lui_x0", 32'h12345037, 32'h0, 32'd3, 32'd4, 5'd0, 5'd0,
         mk(0, 32'h12345000, 32'h12345000, 0, 5'd0, 0, 4'd10, 3'd0, 0, 0, 0, 0, 0));
    // auipc x4,0xFFFFF
    send("auipc", 32'hFFFFF217, 32'h1000, 32'd3, 32'd4, 5'd0, 5'd0,
         mk(32'h1000, 32'hFFFFF000, 32'hFFFFF000, 0, 5'd4, 1, 4'd0, 3'd0, 0, 0, 0, 0, 0));
    // Unknown opcode -> NOP bundle
    send("nop", 32'h0000007F, 32'h2000, 32'hAAAA, 32'hBBBB, 5'd0, 5'd0,
         mk(0, 0, 0, 0, 5'd0, 0, 4'd0, 3'd0, 0, 0, 0, 0, EXP_ILL));

    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.queue", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
